// File: rtl/muldiv_sequencer_if.sv
// Bundle of CPU control, MTHI/MTLO access and divider/multiplier unit signals
// shared between the muldiv sequencer (slave) and its environment (master).
interface muldiv_sequencer_if;
    logic        div_start;
    logic        mult_start;
    logic        abort;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hilo_wdata;

    logic        div_control;
    logic [31:0] div_divisor;
    logic [31:0] div_dividend;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    logic        mult_control;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;

    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    // The master side groups the CPU control FSM with the two arithmetic units.
    modport master (
        output div_start, mult_start, abort, op_a, op_b,
        output hi_we, lo_we, hilo_wdata,
        output div_quo, div_rem, mult_hi, mult_lo,
        input  div_control, div_divisor, div_dividend,
        input  mult_control, mult_a, mult_b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  div_start, mult_start, abort, op_a, op_b,
        input  hi_we, lo_we, hilo_wdata,
        input  div_quo, div_rem, mult_hi, mult_lo,
        output div_control, div_divisor, div_dividend,
        output mult_control, mult_a, mult_b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multi-cycle divider and multiplier: latches operands,
// holds the unit's control high for a fixed run length, then loads HI/LO.
module muldiv_sequencer #(
    parameter int DIV_CYCLES  = 34,
    parameter int MULT_CYCLES = 33,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic reset,
    muldiv_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RUN_DIV,
        RUN_MULT,
        CAPTURE,
        ERR
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      opa, opa_nxt;
    logic [31:0]      opb, opb_nxt;
    logic [31:0]      hi_r, hi_nxt;
    logic [31:0]      lo_r, lo_nxt;
    logic             div_ctl, div_ctl_nxt;
    logic             mult_ctl, mult_ctl_nxt;
    logic             busy_r, busy_nxt;
    logic             done_r, done_nxt;
    logic             zero_r, zero_nxt;
    logic             accept;

    // A start is only taken in IDLE and never alongside abort; MTHI/MTLO
    // writes share IDLE cycles only with requests that were not taken.
    assign accept = (state == IDLE) && !bus.abort && (bus.div_start || bus.mult_start);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        opa_nxt      = opa;
        opb_nxt      = opb;
        hi_nxt       = hi_r;
        lo_nxt       = lo_r;
        div_ctl_nxt  = 1'b0;
        mult_ctl_nxt = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        zero_nxt     = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    busy_nxt = 1'b1;
                    if (bus.div_start && (bus.op_b == 32'd0)) begin
                        state_nxt = ERR;
                        done_nxt  = 1'b1;
                        zero_nxt  = 1'b1;
                    end else begin
                        opa_nxt = bus.op_a;
                        opb_nxt = bus.op_b;
                        cnt_nxt = '0;
                        if (bus.div_start) begin
                            state_nxt   = RUN_DIV;
                            div_ctl_nxt = 1'b1;
                        end else begin
                            state_nxt    = RUN_MULT;
                            mult_ctl_nxt = 1'b1;
                        end
                    end
                end else begin
                    if (bus.hi_we) hi_nxt = bus.hilo_wdata;
                    if (bus.lo_we) lo_nxt = bus.hilo_wdata;
                end
            end

            RUN_DIV: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DIV_LAST) begin
                    state_nxt = CAPTURE;
                    cnt_nxt   = '0;
                    lo_nxt    = bus.div_quo;
                    hi_nxt    = bus.div_rem;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt     = cnt + CNT_ONE;
                    div_ctl_nxt = 1'b1;
                    busy_nxt    = 1'b1;
                end
            end

            RUN_MULT: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == MULT_LAST) begin
                    state_nxt = CAPTURE;
                    cnt_nxt   = '0;
                    hi_nxt    = bus.mult_hi;
                    lo_nxt    = bus.mult_lo;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt      = cnt + CNT_ONE;
                    mult_ctl_nxt = 1'b1;
                    busy_nxt     = 1'b1;
                end
            end

            // Both controls sit low here so each unit clears before its next run.
            CAPTURE: state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            opa      <= '0;
            opb      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            div_ctl  <= 1'b0;
            mult_ctl <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            opa      <= opa_nxt;
            opb      <= opb_nxt;
            hi_r     <= hi_nxt;
            lo_r     <= lo_nxt;
            div_ctl  <= div_ctl_nxt;
            mult_ctl <= mult_ctl_nxt;
            busy_r   <= busy_nxt;
            done_r   <= done_nxt;
            zero_r   <= zero_nxt;
        end
    end

    assign bus.div_control  = div_ctl;
    assign bus.div_dividend = opa;
    assign bus.div_divisor  = opb;
    assign bus.mult_control = mult_ctl;
    assign bus.mult_a       = opa;
    assign bus.mult_b       = opb;
    assign bus.hi           = hi_r;
    assign bus.lo           = lo_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.div_zero     = zero_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed scenarios plus random
// operations compared cycle by cycle against a transaction-level model.
module tb_muldiv_sequencer;

    localparam int DIV_N  = 34;
    localparam int MULT_N = 33;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Idealised arithmetic units: results settle as soon as operands are latched.
    logic [63:0] unit_prod;
    assign unit_prod    = {32'd0, bus.mult_a} * {32'd0, bus.mult_b};
    assign bus.mult_hi  = unit_prod[63:32];
    assign bus.mult_lo  = unit_prod[31:0];
    assign bus.div_quo  = (bus.div_divisor == 32'd0) ? 32'hFFFF_FFFF : bus.div_dividend / bus.div_divisor;
    assign bus.div_rem  = (bus.div_divisor == 32'd0) ? bus.div_dividend : bus.div_dividend % bus.div_divisor;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi, exp_lo, exp_a, exp_b;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        bus.div_start  = 1'b0;
        bus.mult_start = 1'b0;
        bus.abort      = 1'b0;
        bus.hi_we      = 1'b0;
        bus.lo_we      = 1'b0;
    endtask

    // Flags are packed as {div_control, mult_control, busy, done, div_zero}.
    task automatic checkAll(input string tag, input logic [4:0] exp_flags);
        checkOutput({tag, ".flags"}, 64'({bus.div_control, bus.mult_control, bus.busy, bus.done, bus.div_zero}), 64'(exp_flags));
        checkOutput({tag, ".hilo"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
        checkOutput({tag, ".divops"}, {bus.div_dividend, bus.div_divisor}, {exp_a, exp_b});
        checkOutput({tag, ".multops"}, {bus.mult_a, bus.mult_b}, {exp_a, exp_b});
    endtask

    // kind: 0 = DIV, 1 = MULT, 2 = DIV and MULT together. abort_at = run cycle
    // carrying abort (0 = none). Called at a negedge with the DUT idle; returns
    // at the first negedge where the DUT is idle again.
    task automatic applyStimulus(input string tag, input int kind, input logic [31:0] a,
                                 input logic [31:0] b, input int abort_at, input bit noise);
        bit          is_div, is_err, aborted;
        int          n, done_cyc, last;
        logic [63:0] prod;
        is_div   = (kind != 1);
        is_err   = is_div && (b == 32'd0);
        n        = is_err ? 1 : (is_div ? DIV_N : MULT_N);
        aborted  = !is_err && (abort_at != 0);
        done_cyc = is_err ? 1 : n + 1;
        last     = aborted ? abort_at + 1 : done_cyc + 1;

        bus.div_start  = is_div;
        bus.mult_start = (kind != 0);
        bus.op_a       = a;
        bus.op_b       = b;
        if (noise) begin
            bus.hi_we      = 1'b1;
            bus.lo_we      = 1'b1;
            bus.hilo_wdata = $urandom;
        end
        if (!is_err) begin
            exp_a = a;
            exp_b = b;
        end

        for (int c = 1; c <= last; c++) begin
            bit ctl_on, bsy;
            @(negedge clk);
            ctl_on = !is_err && (c <= n) && (!aborted || c <= abort_at);
            bsy    = aborted ? (c <= abort_at) : (c <= done_cyc);
            if (c == done_cyc && !aborted && !is_err) begin
                if (is_div) begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end else begin
                    prod   = {32'd0, a} * {32'd0, b};
                    exp_hi = prod[63:32];
                    exp_lo = prod[31:0];
                end
            end
            checkAll(tag, {ctl_on && is_div, ctl_on && !is_div, bsy,
                           !aborted && (c == done_cyc), is_err && (c == 1)});

            clearInputs();
            if (bsy && noise) begin
                bus.div_start  = 1'($urandom_range(0, 1));
                bus.mult_start = 1'($urandom_range(0, 1));
                bus.op_a       = $urandom;
                bus.op_b       = $urandom;
                bus.hi_we      = 1'($urandom_range(0, 1));
                bus.lo_we      = 1'($urandom_range(0, 1));
                bus.hilo_wdata = $urandom;
            end
            if (aborted && c == abort_at)
                bus.abort = 1'b1;
            else if (bsy && noise && c == done_cyc)
                bus.abort = 1'b1;
        end
    endtask

    task automatic writeHiLo(input string tag, input bit hw, input bit lw, input logic [31:0] data);
        bus.hi_we      = hw;
        bus.lo_we      = lw;
        bus.hilo_wdata = data;
        @(negedge clk);
        if (hw) exp_hi = data;
        if (lw) exp_lo = data;
        checkAll(tag, 5'b00000);
        clearInputs();
    endtask

    initial begin
        int          kind, abort_at;
        logic [31:0] a, b;

        reset          = 1'b1;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.hilo_wdata = '0;
        clearInputs();
        exp_hi = '0;
        exp_lo = '0;
        exp_a  = '0;
        exp_b  = '0;

        @(negedge clk);
        checkAll("reset", 5'b00000);
        reset = 1'b0;
        @(negedge clk);
        checkAll("post_reset", 5'b00000);

        applyStimulus("div_100_7", 0, 32'd100, 32'd7, 0, 1'b0);
        checkOutput("div_100_7.lo", 64'(bus.lo), 64'd14);
        checkOutput("div_100_7.hi", 64'(bus.hi), 64'd2);

        applyStimulus("div_by_zero", 0, 32'd5, 32'd0, 0, 1'b0);
        checkOutput("div_by_zero.hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});

        applyStimulus("mult_max_2", 1, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
        checkOutput("mult_max_2.hilo", {bus.hi, bus.lo}, {32'h1, 32'hFFFF_FFFE});

        applyStimulus("both_starts", 2, 32'd1000, 32'd33, 0, 1'b1);
        applyStimulus("abort_div_10", 0, 32'd77777, 32'd13, 10, 1'b0);
        applyStimulus("after_abort", 1, 32'd12345, 32'd678, 0, 1'b0);
        applyStimulus("abort_mult_last", 1, 32'hDEAD_BEEF, 32'h1234_5678, MULT_N, 1'b1);

        writeHiLo("mtlo", 1'b0, 1'b1, 32'h0000_DEAD);
        writeHiLo("mthi", 1'b1, 1'b0, 32'hCAFE_F00D);
        writeHiLo("mthi_mtlo", 1'b1, 1'b1, 32'h1357_9BDF);

        // abort alongside a start in IDLE: the start must not be taken
        bus.div_start = 1'b1;
        bus.abort     = 1'b1;
        bus.op_a      = 32'd9;
        bus.op_b      = 32'd3;
        @(negedge clk);
        checkAll("abort_with_start", 5'b00000);
        clearInputs();

        for (int i = 0; i < 16; i++) begin
            kind = $urandom_range(0, 2);
            a    = $urandom;
            b    = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            abort_at = 0;
            if ($urandom_range(0, 3) == 0)
                abort_at = $urandom_range(1, (kind == 1) ? MULT_N : DIV_N);
            applyStimulus("random_op", kind, a, b, abort_at, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0)
                writeHiLo("random_write", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        // Asynchronous reset in the middle of a divide
        bus.div_start = 1'b1;
        bus.op_a      = 32'd50;
        bus.op_b      = 32'd3;
        @(negedge clk);
        clearInputs();
        checkOutput("pre_reset.busy", 64'(bus.busy), 64'd1);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        exp_a  = '0;
        exp_b  = '0;
        checkAll("async_reset", 5'b00000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkAll("after_async_reset", 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the shared multi-cycle divider and multiplier units for the multicycle CPU.
- Accepts DIV/MULT start pulses from the control FSM and latches the operands.
- Holds the selected unit's control line high for a fixed number of cycles, then captures the results into architectural HI/LO.
- Detects divide-by-zero before starting the divider and flags it.
- Provides busy for stalling and MTHI/MTLO write access.

Parameters:
- DIV_CYCLES, 34, cycles div_control stays high per divide (unit latency including operand load).
- MULT_CYCLES, 33, cycles mult_control stays high per multiply.
- CNT_W, 6, run-counter width; must hold max(DIV_CYCLES, MULT_CYCLES).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- div_start  in  1  one-cycle request: DIV op_a / op_b.
- mult_start  in  1  one-cycle request: MULT op_a * op_b.
- abort  in  1  synchronous flush of the operation in flight.
- op_a  in  32  rs operand (dividend / multiplicand).
- op_b  in  32  rt operand (divisor / multiplier).
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- hilo_wdata  in  32  MTHI/MTLO data.
- div_control  out  1  divider run/clear control.
- div_divisor  out  32  latched op_b to divider.
- div_dividend  out  32  latched op_a to divider.
- div_quo  in  32  divider quotient.
- div_rem  in  32  divider remainder.
- mult_control  out  1  multiplier run/clear control.
- mult_a  out  32  latched op_a.
- mult_b  out  32  latched op_b.
- mult_hi  in  32  product upper word.
- mult_lo  in  32  product lower word.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- busy  out  1  operation in flight; CPU must stall.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle divide-by-zero exception pulse (coincides with done).

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counter=0, all latched operands=0, hi=lo=0, div_control=mult_control=busy=done=div_zero=0.
- States: IDLE, RUN_DIV, RUN_MULT, CAPTURE, ERR.
- All outputs are registered.
- Accept in IDLE, cycle T:
  - div_start=1 and op_b!=0 -> latch operands, counter=0, state RUN_DIV.
  - div_start=1 and op_b==0 -> state ERR; nothing latched.
  - else mult_start=1 -> latch operands, state RUN_MULT.
  - Both starts high together -> DIV wins; MULT is dropped, not queued.
- RUN_x:
  - x_control=1 for exactly N cycles (T+1..T+N), N=DIV_CYCLES or MULT_CYCLES.
  - Counter increments each cycle; on the edge ending the Nth cycle: DIV -> lo<=div_quo, hi<=div_rem; MULT -> hi<=mult_hi, lo<=mult_lo; state CAPTURE.
  - Latched operand outputs remain constant for the whole run.
- CAPTURE (cycle T+N+1): done=1, controls=0, then IDLE.
  - Guarantees each unit sees control=0 for at least one cycle between operations, which clears its internal state.
- ERR (cycle T+1): done=1, div_zero=1, div_control never asserted, hi/lo unchanged, then IDLE.
- busy: 1 in RUN_DIV, RUN_MULT, CAPTURE and ERR; 0 in IDLE.
  - Earliest next accept is T+N+2 (T+2 after ERR).
- Starts while not IDLE are ignored; no queueing.
- abort:
  - In RUN_x: drop control the next cycle, state IDLE, hi/lo unchanged, no done/div_zero.
  - In CAPTURE/ERR: ignored; the pulse still completes.
  - In IDLE: no effect.
  - abort in the same cycle as a start in IDLE: start is not accepted.
- MTHI/MTLO:
  - In IDLE with no start accepted that cycle: hi_we loads hi, lo_we loads lo (both may fire together).
  - Writes while busy, or in the cycle a start is accepted, are dropped.
  - A write in the same IDLE cycle as an ERR-causing div_start is dropped.
- Counter never wraps: N <= 2^CNT_W - 1 is required; parameter violation is out of scope.

Test Plan:
- Reset, then div_start with op_a=100, op_b=7 at T -> div_control high T+1..T+34; done=1 at T+35 with lo=14, hi=2; busy=0 at T+36.
- div_start with op_a=5, op_b=0 -> div_control stays 0; done=div_zero=1 at T+1 only; hi/lo keep prior values.
- mult_start with op_a=0xFFFFFFFF, op_b=2 (unit model returns hi=0x1, lo=0xFFFFFFFE) -> hi/lo loaded, done at T+34.
- div_start and mult_start together, then mult_start pulses while busy -> only the divide runs, mult_control never asserts, and a single done pulse occurs.
- abort at T+10 of a divide -> div_control=0 from T+11, no done, hi/lo unchanged; a new start at T+12 is accepted.
- lo_we=1 with hilo_wdata=0xDEAD in IDLE -> lo=0xDEAD next cycle; same write while busy -> lo unchanged; async reset mid-run -> all outputs 0 immediately, without waiting for a clock edge.
